multiseg_scan_ctrl: RTL

MULTISEG_SCAN_CTRL -- requirements
Module: multiseg_scan_ctrl

---
 rtl/multiseg_scan_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/multiseg_scan_ctrl.sv
// rtl/multiseg_scan_ctrl.sv - binary to BCD conversion with a multiplexed 7-segment scan
// Leading-zero blanking is enabled by defining MULTISEG_LZB_EN.
module multiseg_scan_ctrl #(
   parameter int N_DIGITS    = 4,
   parameter int BIN_W       = 12,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [BIN_W-1:0]    bin_in,
   output logic                busy,
   output logic                overflow,
   output logic [N_DIGITS-1:0] seg_anode,
   output logic [6:0]          seg_cathode
);
   localparam int BCD_W = 4 * N_DIGITS;
   localparam int IT_W  = $clog2(BIN_W + 1);
   localparam int REF_W = $clog2(REFRESH_DIV);
   localparam int SEL_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

   function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < N_DIGITS; i++)
         if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      return r;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   logic [1:0]          state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
   logic [IT_W-1:0]     it_q, it_d;
   logic                ovf_cap_q, ovf_cap_d;
   logic [BCD_W-1:0]    disp_bcd_q, disp_bcd_d;
   logic                disp_ovf_q, disp_ovf_d;
   logic [REF_W-1:0]    refresh_q, refresh_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [N_DIGITS-1:0] seg_anode_q;
   logic [6:0]          seg_cathode_q;
   logic [3:0]          digit;
   logic                blank;

   assign bcd_adj = dabble_adjust(bcd_q);

   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      it_d       = it_q;
      ovf_cap_d  = ovf_cap_q;
      disp_bcd_d = disp_bcd_q;
      disp_ovf_d = disp_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               state_d   = ST_SHIFT;
               bin_d     = bin_in;
               bcd_d     = '0;
               it_d      = '0;
               ovf_cap_d = 64'(bin_in) > MAX_VAL;
            end
         end
         ST_SHIFT: begin
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_d = bin_q << 1;
            it_d  = it_q + IT_W'(1);
            if (it_q == IT_W'(BIN_W - 1)) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            // display value and its overflow flag switch together, never a partial result
            disp_bcd_d = bcd_q;
            disp_ovf_d = ovf_cap_q;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      refresh_d = refresh_q + REF_W'(1);
      sel_d     = sel_q;
      if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         sel_d     = (sel_q == SEL_W'(N_DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
      end
   end

`ifdef MULTISEG_LZB_EN
   logic zero_acc;
`endif

   always_comb begin
      digit = 4'd0;
      blank = 1'b0;
`ifdef MULTISEG_LZB_EN
      zero_acc = 1'b1;
`endif
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
`ifdef MULTISEG_LZB_EN
         // zero_acc: this digit and every digit above it are zero
         zero_acc = zero_acc & (disp_bcd_q[4*i +: 4] == 4'd0);
         if (i != 0 && zero_acc && sel_q == SEL_W'(i)) blank = 1'b1;
`endif
         if (sel_q == SEL_W'(i)) digit = disp_bcd_q[4*i +: 4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         bin_q         <= '0;
         bcd_q         <= '0;
         it_q          <= '0;
         ovf_cap_q     <= 1'b0;
         disp_bcd_q    <= '0;
         disp_ovf_q    <= 1'b0;
         refresh_q     <= '0;
         sel_q         <= '0;
         seg_anode_q   <= '1;
         seg_cathode_q <= 7'b1111111;
      end else begin
         state_q       <= state_d;
         bin_q         <= bin_d;
         bcd_q         <= bcd_d;
         it_q          <= it_d;
         ovf_cap_q     <= ovf_cap_d;
         disp_bcd_q    <= disp_bcd_d;
         disp_ovf_q    <= disp_ovf_d;
         refresh_q     <= refresh_d;
         sel_q         <= sel_d;
         seg_anode_q   <= ~(N_DIGITS'(1) << sel_q);
         if (disp_ovf_q)
            seg_cathode_q <= 7'b0111111;
         else if (blank)
            seg_cathode_q <= 7'b1111111;
         else
            seg_cathode_q <= seg_code(digit);
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign overflow    = disp_ovf_q;
   assign seg_anode   = seg_anode_q;
   assign seg_cathode = seg_cathode_q;

endmodule
